fetch_unit: RTL and testbench

- Instruction fetch and sequencing block for the single-cycle datapath.
- Owns the PC and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Presents the instruction and its opcode field (instr[31:26]) to the control unit.
- Consumes the resolved branch/jump control back from the datapath to select the next PC; it is the producer/consumer at the opposite end of the control-unit interface.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch and sequencing for the single-cycle datapath. Owns the
//   PC, fetches one 32-bit word per instruction over a req/ack handshake,
//   presents it to the control unit, and picks the next PC from the resolved
//   branch/jump controls when the datapath reports completion.
//
// Ports
//   clk, rst_n           : clock (rising edge), async active-low reset
//   imem_req/imem_addr   : fetch request and address (addr == pc while req)
//   imem_rdata/imem_ack  : returned word and its completion strobe
//   instr/opcode         : latched instruction and its [31:26] field
//   instr_valid          : instr/opcode valid for execution
//   exec_done            : current instruction executed; controls valid
//   branch/jump/alu_zero : next-PC controls from control unit / ALU
//   pc                   : address of the current instruction
//   halted               : halt opcode (6'h3F) retired, fetching stopped
// -----------------------------------------------------------------------------
module fetch_unit #(
  // Jump target splices in 28 low bits, so ADDR_W must exceed 28.
  parameter int unsigned              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              branch,
  input  logic              jump,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              halted_q;

  // ---------------------------------------------------------------------------
  // Next-PC selection. All sums wrap modulo 2^ADDR_W.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] pc_d;

  assign pc4     = pc_q + ADDR_W'(4);
  // Region bits come from pc+4, not pc, so a jump in the last slot of a
  // 256 MiB region lands in the following region.
  assign jmp_tgt = {pc4[ADDR_W-1:28], instr_q[25:0], 2'b00};
  // Word offset, sign-extended then scaled to bytes.
  assign br_off  = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    pc_d = pc4;
    if (jump)
      pc_d = jmp_tgt;
    else if (branch && alu_zero)
      pc_d = pc4 + br_off;
  end

  // ---------------------------------------------------------------------------
  // Sequencer. Every output except opcode is a register updated here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        // Single settle cycle after reset; any ack seen here belongs to an
        // aborted request and is dropped.
        IDLE: begin
          req_q   <= 1'b1;
          addr_q  <= pc_q;
          state_q <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (exec_done) begin
            valid_q <= 1'b0;
            if (instr_q[31:26] == OP_HALT) begin
              // Halt ignores branch/jump: pc simply steps past it.
              halted_q <= 1'b1;
              pc_q     <= pc4;
              state_q  <= HALT;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              addr_q  <= pc_d;
              state_q <= FETCH;
            end
          end
        end
        HALT: begin
          // Terminal until reset.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int unsigned ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] pc;
  logic        halted;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .exec_done(exec_done), .branch(branch), .jump(jump), .alu_zero(alu_zero),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard: expected fetch addresses and expected latched words.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard whenever the DUT presents a new request or
  // a new instruction, and checks hold-stability while they stay asserted.
  // ---------------------------------------------------------------------------
  logic        prev_req = 1'b0;
  logic        prev_vld = 1'b0;
  logic [31:0] held_addr, held_instr, mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      prev_vld = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
        end else begin
          mon_e = exp_addr_q.pop_front();
          chk("fetch_addr", imem_addr, mon_e);
          chk("fetch_pc", pc, mon_e);
        end
        held_addr = imem_addr;
      end else if (imem_req) begin
        chk("addr_stable", imem_addr, held_addr);
      end

      if (instr_valid && !prev_vld) begin
        if (exp_instr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_instr: got instr %h expected none", instr);
        end else begin
          mon_e = exp_instr_q.pop_front();
          chk("instr", instr, mon_e);
          chk("opcode", {26'b0, opcode}, {26'b0, mon_e[31:26]});
        end
        held_instr = instr;
      end else if (instr_valid) begin
        chk("instr_stable", instr, held_instr);
      end

      if (halted) chk("halt_no_req", {31'b0, imem_req}, 32'd0);
      prev_req = imem_req;
      prev_vld = instr_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
    return w;
  endfunction

  // Reference next-PC: plain address arithmetic from the ISA rules.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input logic br, input logic jp, input logic z);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jp)           return (seq & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
    else if (br && z) return seq + 32'(int'($signed(w[15:0])) * 4);
    else              return seq;
  endfunction

  task automatic apply_reset(input bit stale_ack);
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_addr_q.push_back(RESET_PC);
    model_pc = RESET_PC;
    rst_n = 1'b1;
    if (stale_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end
    @(posedge clk); #1;
    imem_ack = 1'b0;
  endtask

  // One instruction: answer the fetch after da cycles, execute after de cycles.
  // Inputs that the DUT must ignore are randomised while they do not matter.
  task automatic do_instr(input logic [31:0] w, input int da, input int de,
                          input logic br, input logic jp, input logic z);
    int n = 0;
    while (!imem_req && n < 50) begin @(posedge clk); #1; n++; end
    if (!imem_req) begin
      tests++; fails++;
      $display("FAIL req_timeout: got no request after %0d cycles expected imem_req=1", n);
      return;
    end
    repeat (da) begin
      imem_ack  = 1'b0;
      exec_done = 1'($urandom);
      {branch, jump, alu_zero} = 3'($urandom);
      @(posedge clk); #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    exec_done  = 1'($urandom);
    exp_instr_q.push_back(w);
    @(posedge clk); #1;
    repeat (de) begin
      exec_done  = 1'b0;
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      {branch, jump, alu_zero} = 3'($urandom);
      @(posedge clk); #1;
    end
    exec_done = 1'b1;
    imem_ack  = 1'b0;
    branch    = br;
    jump      = jp;
    alu_zero  = z;
    @(posedge clk); #1;
    exec_done = 1'b0;
    if (w[31:26] == 6'h3F) begin
      model_pc = model_pc + 32'd4;
    end else begin
      model_pc = ref_next(model_pc, w, br, jp, z);
      exp_addr_q.push_back(model_pc);
    end
  endtask

  task automatic plain(input logic [31:0] w);
    do_instr(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    apply_reset(1'b0);

    // Sequential fetch, delayed ack.
    do_instr(32'h0400_0000, 3, 1, 1'b0, 1'b0, 1'b0);
    plain(rand_word()); plain(rand_word()); plain(rand_word());   // 4, 8, C
    // Branch at 0x10, offset -2 words: taken then not taken.
    do_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1);              // -> 0x0C
    plain(rand_word());                                           // 0x0C -> 0x10
    do_instr(32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b0);              // -> 0x14
    plain(rand_word()); plain(rand_word()); plain(rand_word());   // -> 0x20
    // Jump wins over branch.
    do_instr(32'h0800_0040, 0, 2, 1'b1, 1'b1, 1'b1);              // -> 0x100
    chk("jump_model", model_pc, 32'h100);

    // Randomised instruction stream.
    for (int i = 0; i < 150; i++)
      do_instr(rand_word(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));

    // Halt, with controls that would otherwise redirect.
    do_instr(32'hFC00_1234, 1, 1, 1'b1, 1'b1, 1'b1);
    chk("halted", {31'b0, halted}, 32'd1);
    chk("halt_pc", pc, model_pc);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      imem_ack   = 1'($urandom);
      exec_done  = 1'($urandom);
      imem_rdata = $urandom;
      {branch, jump, alu_zero} = 3'($urandom);
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; exec_done = 1'b0;
    chk("halt_sticky", {31'b0, halted}, 32'd1);
    chk("halt_pc_hold", pc, model_pc);

    // Reset (also clears halt), then abort a fetch mid-wait.
    apply_reset(1'b0);
    begin
      int n = 0;
      while (!imem_req && n < 50) begin @(posedge clk); #1; n++; end
    end
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    apply_reset(1'b1);   // stale ack offered in the IDLE cycle
    do_instr(32'h0400_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    plain(rand_word());

    repeat (4) @(posedge clk);
    #1;
    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
